need_update_arbiter: RTL and testbench

Sequencer for the tamagotchi stat datapath. Collects player actions (salud, hambre, energia, diversion buttons/sensors) and periodic decay events, and serialises them onto the single update port of the need-level register file, one update at a time, under a valid/ready handshake. It also owns test mode, which shortens the decay period so the FSM can be exercised in simulation and on the board.

---
 rtl/tamagotchi_pkg.sv | 17 +
 rtl/need_update_arbiter_if.sv | 24 ++
 rtl/decay_timer.sv | 42 ++++
 rtl/need_update_arbiter.sv | 138 +++++++++++++
 tb/tb_need_update_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tamagotchi_pkg.sv
// Shared constants and arbiter state encoding
// for the tamagotchi need-level datapath.
package tamagotchi_pkg;

  localparam int NUM_NEEDS = 4;

  localparam logic [1:0] NEED_SALUD     = 2'd0;
  localparam logic [1:0] NEED_HAMBRE    = 2'd1;
  localparam logic [1:0] NEED_ENERGIA   = 2'd2;
  localparam logic [1:0] NEED_DIVERSION = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } arb_state_e;

endpackage

// File: rtl/need_update_arbiter_if.sv
// Update port between the need arbiter and
// the need-level register file.
interface need_update_arbiter_if;

  logic       upd_valid;
  logic       upd_ready;
  logic [1:0] upd_need;
  logic       upd_inc;

  modport master (
    output upd_valid,
    output upd_need,
    output upd_inc,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_need,
    input  upd_inc,
    output upd_ready
  );

endinterface

// File: rtl/decay_timer.sv
// Free-running decay period counter with a
// mode-selected period and synchronous clear.
module decay_timer #(
  parameter int DECAY_TICKS = 50_000_000,
  parameter int TEST_TICKS  = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic test_mode,
  input  logic clr,
  output logic tick
);

  localparam int MAX_TICKS =
    (DECAY_TICKS > TEST_TICKS) ?
    DECAY_TICKS : TEST_TICKS;
  localparam int W =
    (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  logic [W-1:0] cnt;
  logic [W-1:0] last;
  logic         term;

  assign last = test_mode ?
    W'(TEST_TICKS - 1) : W'(DECAY_TICKS - 1);
  assign term = (cnt == last);

  // a clear restarts the period, so it masks
  // any terminal count on the same edge
  assign tick = term & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || term) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/need_update_arbiter.sv
// Serialises player actions and decay events
// onto the single need register-file update port.
module need_update_arbiter
  import tamagotchi_pkg::*;
#(
  parameter int DECAY_TICKS = 50_000_000,
  parameter int TEST_TICKS  = 50_000
) (
  input  logic clk,
  input  logic btn_reset,
  input  logic btn_salud,
  input  logic btn_hambre,
  input  logic btn_energia,
  input  logic btn_diversion,
  input  logic btn_test,
  need_update_arbiter_if.master upd,
  output logic       test_mode,
  output logic [7:0] pend
);

  logic [NUM_NEEDS-1:0] btn;
  logic [NUM_NEEDS-1:0] prev;
  logic [NUM_NEEDS-1:0] rise;
  logic [NUM_NEEDS-1:0] inc_pend;
  logic [NUM_NEEDS-1:0] dec_pend;
  logic [NUM_NEEDS-1:0] inc_clr;
  logic [NUM_NEEDS-1:0] dec_clr;
  logic [NUM_NEEDS-1:0] has;

  logic       test_prev;
  logic       test_rise;
  logic       tick;
  logic       still;

  arb_state_e state;
  arb_state_e state_nxt;

  logic [1:0] rr;
  logic [1:0] rr_nxt;
  logic [1:0] sel;
  logic [1:0] need_q;
  logic [1:0] need_nxt;
  logic       inc_q;
  logic       inc_nxt;

  assign btn = {btn_diversion, btn_energia,
                btn_hambre, btn_salud};
  assign rise      = btn & ~prev;
  assign test_rise = btn_test & ~test_prev;
  assign has       = inc_pend | dec_pend;

  decay_timer #(
    .DECAY_TICKS (DECAY_TICKS),
    .TEST_TICKS  (TEST_TICKS)
  ) u_timer (
    .clk       (clk),
    .rst_n     (btn_reset),
    .test_mode (test_mode),
    .clr       (test_rise),
    .tick      (tick)
  );

  // lowest offset from rr with work wins
  always_comb begin
    sel = rr;
    for (int k = NUM_NEEDS - 1; k >= 0; k--) begin
      if (has[rr + 2'(k)]) begin
        sel = rr + 2'(k);
      end
    end
  end

  // need keeps priority if anything is left
  // for it once the served bit is cleared
  assign still = rise[need_q] | tick |
    (inc_q ? dec_pend[need_q] : inc_pend[need_q]);

  always_comb begin
    state_nxt = state;
    need_nxt  = need_q;
    inc_nxt   = inc_q;
    rr_nxt    = rr;
    inc_clr   = '0;
    dec_clr   = '0;
    unique case (state)
      ST_IDLE: begin
        if (|has) begin
          need_nxt  = sel;
          inc_nxt   = inc_pend[sel];
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (upd.upd_ready) begin
          if (inc_q) begin
            inc_clr[need_q] = 1'b1;
          end else begin
            dec_clr[need_q] = 1'b1;
          end
          rr_nxt    = still ? need_q
                            : need_q + 2'd1;
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      state     <= ST_IDLE;
      prev      <= '0;
      test_prev <= 1'b0;
      test_mode <= 1'b0;
      inc_pend  <= '0;
      dec_pend  <= '0;
      rr        <= '0;
      need_q    <= '0;
      inc_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev      <= btn;
      test_prev <= btn_test;
      test_mode <= test_mode ^ test_rise;
      inc_pend  <= (inc_pend & ~inc_clr) | rise;
      dec_pend  <= (dec_pend & ~dec_clr) |
                   {NUM_NEEDS{tick}};
      rr        <= rr_nxt;
      need_q    <= need_nxt;
      inc_q     <= inc_nxt;
    end
  end

  assign upd.upd_valid = (state == ST_ISSUE);
  assign upd.upd_need  = need_q;
  assign upd.upd_inc   = inc_q;
  assign pend          = {dec_pend, inc_pend};

endmodule

// File: tb/tb_need_update_arbiter.sv
// Scoreboard bench for need_update_arbiter with
// short decay periods (20 normal, 4 test).
module tb_need_update_arbiter;

  typedef struct {
    logic [1:0] need;
    logic       inc;
    int         at;
  } exp_t;

  logic clk = 1'b0;
  logic btn_reset = 1'b0;
  logic btn_salud = 1'b0;
  logic btn_hambre = 1'b0;
  logic btn_energia = 1'b0;
  logic btn_diversion = 1'b0;
  logic btn_test = 1'b0;
  logic test_mode;
  logic [7:0] pend;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  exp_t q[$];

  logic       stall = 1'b0;
  logic [1:0] s_need = '0;
  logic       s_inc = 1'b0;

  need_update_arbiter_if bus ();

  need_update_arbiter #(
    .DECAY_TICKS (20),
    .TEST_TICKS  (4)
  ) dut (
    .clk           (clk),
    .btn_reset     (btn_reset),
    .btn_salud     (btn_salud),
    .btn_hambre    (btn_hambre),
    .btn_energia   (btn_energia),
    .btn_diversion (btn_diversion),
    .btn_test      (btn_test),
    .upd           (bus),
    .test_mode     (test_mode),
    .pend          (pend)
  );

  always #5 clk = ~clk;

  // edge number since the last reset release
  always @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic push(input int need,
                      input int inc,
                      input int at);
    exp_t e;
    e.need = 2'(need);
    e.inc  = inc[0];
    e.at   = at;
    q.push_back(e);
  endtask

  task automatic at_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL at_cyc_timeout: got %0d expected %0d",
               cyc, n);
    end
  endtask

  task automatic clr_btns();
    btn_salud = 1'b0;
    btn_hambre = 1'b0;
    btn_energia = 1'b0;
    btn_diversion = 1'b0;
    btn_test = 1'b0;
  endtask

  // caller sits just after a rising edge
  task automatic do_reset();
    btn_reset = 1'b0;
    clr_btns();
    bus.upd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    btn_reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!btn_reset) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", int'(bus.upd_valid), 1);
        chk("hold_need", int'(bus.upd_need),
            int'(s_need));
        chk("hold_inc", int'(bus.upd_inc),
            int'(s_inc));
      end
      if (bus.upd_valid && bus.upd_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_xfer: got need %0d inc %0d at %0d expected none",
                   bus.upd_need, bus.upd_inc, cyc + 1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("xfer_need", int'(bus.upd_need),
              int'(e.need));
          chk("xfer_inc", int'(bus.upd_inc),
              int'(e.inc));
          chk("xfer_cycle", cyc + 1, e.at);
        end
      end
      stall  = bus.upd_valid && !bus.upd_ready;
      s_need = bus.upd_need;
      s_inc  = bus.upd_inc;
    end
  end

  initial begin
    bus.upd_ready = 1'b0;
    #1;
    do_reset();

    // reset state
    chk("rst_valid", int'(bus.upd_valid), 0);
    chk("rst_need", int'(bus.upd_need), 0);
    chk("rst_inc", int'(bus.upd_inc), 0);
    chk("rst_test_mode", int'(test_mode), 0);
    chk("rst_pend", int'(pend), 0);

    // single press, held for 10 cycles
    bus.upd_ready = 1'b1;
    push(0, 1, 4);
    at_cyc(1);
    btn_salud = 1'b1;
    at_cyc(2);
    chk("sp_pend", int'(pend), 'h01);
    at_cyc(3);
    chk("sp_valid_hi", int'(bus.upd_valid), 1);
    at_cyc(4);
    chk("sp_valid_lo", int'(bus.upd_valid), 0);
    at_cyc(11);
    btn_salud = 1'b0;
    at_cyc(14);
    chk("sp_pend_end", int'(pend), 0);
    chk("sp_sb_empty", q.size(), 0);
    do_reset();

    // back-pressure with a second press
    push(1, 1, 8);
    push(3, 1, 10);
    at_cyc(1);
    btn_hambre = 1'b1;
    at_cyc(3);
    btn_diversion = 1'b1;
    at_cyc(5);
    chk("bp_valid", int'(bus.upd_valid), 1);
    chk("bp_need", int'(bus.upd_need), 1);
    chk("bp_pend", int'(pend), 'h0A);
    at_cyc(7);
    bus.upd_ready = 1'b1;
    at_cyc(12);
    clr_btns();
    at_cyc(15);
    chk("bp_sb_empty", q.size(), 0);
    do_reset();

    // round-robin across all four needs
    bus.upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(i, 1, 4 + 2 * i);
    at_cyc(1);
    btn_salud = 1'b1;
    btn_hambre = 1'b1;
    btn_energia = 1'b1;
    btn_diversion = 1'b1;
    at_cyc(2);
    chk("rr_pend", int'(pend), 'h0F);
    at_cyc(12);
    clr_btns();
    at_cyc(14);
    chk("rr_sb_empty", q.size(), 0);
    do_reset();

    // decay in normal mode, then test mode
    bus.upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(i, 0, 22 + 2 * i);
    push(0, 0, 37);
    push(1, 0, 39);
    push(1, 0, 41);
    push(2, 0, 43);
    push(2, 0, 45);
    push(3, 0, 47);
    push(3, 0, 49);
    push(0, 0, 51);
    at_cyc(21);
    chk("dk_pend", int'(pend), 'hF0);
    at_cyc(30);
    btn_test = 1'b1;
    at_cyc(31);
    chk("tm_on", int'(test_mode), 1);
    at_cyc(33);
    btn_test = 1'b0;
    at_cyc(35);
    chk("tm_first_tick", int'(pend), 'hF0);
    at_cyc(36);
    chk("tm_valid", int'(bus.upd_valid), 1);
    chk("tm_need", int'(bus.upd_need), 0);
    at_cyc(42);
    chk("tm_merge_pend", int'(pend), 'hD0);
    at_cyc(51);
    chk("tm_sb_empty", q.size(), 0);
    do_reset();
    chk("tm_off_rst", int'(test_mode), 0);

    // press colliding with a decay tick
    bus.upd_ready = 1'b1;
    push(0, 1, 22);
    push(0, 0, 24);
    push(1, 0, 26);
    push(2, 0, 28);
    push(3, 0, 30);
    at_cyc(19);
    btn_salud = 1'b1;
    at_cyc(21);
    chk("col_pend", int'(pend), 'hF1);
    at_cyc(25);
    btn_salud = 1'b0;
    at_cyc(32);
    chk("col_sb_empty", q.size(), 0);
    do_reset();

    // asynchronous reset while issuing
    at_cyc(1);
    btn_test = 1'b1;
    at_cyc(3);
    btn_hambre = 1'b1;
    at_cyc(6);
    chk("ar_valid_pre", int'(bus.upd_valid), 1);
    chk("ar_tm_pre", int'(test_mode), 1);
    #2;
    btn_reset = 1'b0;
    #1;
    chk("ar_valid", int'(bus.upd_valid), 0);
    chk("ar_pend", int'(pend), 0);
    chk("ar_test_mode", int'(test_mode), 0);
    clr_btns();
    @(posedge clk);
    #1;
    btn_reset = 1'b1;
    at_cyc(10);
    chk("ar_idle_valid", int'(bus.upd_valid), 0);
    chk("ar_idle_pend", int'(pend), 0);
    chk("ar_sb_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
